// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer
// Walks a parallel ROM from a latched start address to a latched end address.
// Each cell is read with a programmable setup phase (address + chip-select
// stable before output-enable) and a programmable access phase (output-enable
// low before the data bus is sampled). The captured byte and its address are
// handed downstream on a valid/ready handshake before the next cell is read.
// Every output is driven straight from a register so the ROM pins and the
// address display see glitch-free levels.
module rom_read_sequencer #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int ACCESS_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [ADDR_WIDTH-1:0] end_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  data_ready,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_cs_n,
    output logic                  rom_oe_n,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  range_error
);

    // Phase counters count 0..N-1; the transition happens on the last count.
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] ACCESS_LAST = 8'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HANDOFF,
        ST_FINISH
    } state_t;

    state_t                state_reg;
    logic [7:0]            phase_cnt_reg;
    // Only the end of the range needs to be kept; the start address lives in
    // rom_address itself once the sweep begins, so the range inputs are free
    // to change while busy.
    logic [ADDR_WIDTH-1:0] end_addr_reg;

    // Sweep sequencer: state, phase counter, ROM strobes and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_cnt_reg <= 8'd0;
            end_addr_reg  <= '0;
            rom_address   <= '0;
            rom_cs_n      <= 1'b1;
            rom_oe_n      <= 1'b1;
            data_out      <= '0;
            data_addr     <= '0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            range_error   <= 1'b0;
        end else begin
            // done and range_error are single-cycle pulses unless re-armed below.
            done        <= 1'b0;
            range_error <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (end_address >= start_address) begin
                            end_addr_reg  <= end_address;
                            rom_address   <= start_address;
                            rom_cs_n      <= 1'b0;
                            busy          <= 1'b1;
                            phase_cnt_reg <= 8'd0;
                            state_reg     <= ST_SETUP;
                        end else begin
                            // Empty range: report and stay put, ROM untouched.
                            done        <= 1'b1;
                            range_error <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    if (phase_cnt_reg == SETUP_LAST) begin
                        phase_cnt_reg <= 8'd0;
                        rom_oe_n      <= 1'b0;
                        state_reg     <= ST_ACCESS;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 8'd1;
                    end
                end

                ST_ACCESS: begin
                    if (phase_cnt_reg == ACCESS_LAST) begin
                        // Sample while OE is still low; release OE on the same edge.
                        phase_cnt_reg <= 8'd0;
                        data_out      <= rom_data;
                        data_addr     <= rom_address;
                        data_valid    <= 1'b1;
                        rom_oe_n      <= 1'b1;
                        state_reg     <= ST_HANDOFF;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 8'd1;
                    end
                end

                ST_HANDOFF: begin
                    // data_valid is always 1 here, so ready alone completes the transfer.
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        if (rom_address == end_addr_reg) begin
                            // Compare before incrementing so the top address never wraps.
                            rom_cs_n  <= 1'b1;
                            done      <= 1'b1;
                            state_reg <= ST_FINISH;
                        end else begin
                            rom_address <= rom_address + ADDR_STEP;
                            state_reg   <= ST_SETUP;
                        end
                    end
                end

                ST_FINISH: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Directed testbench for rom_read_sequencer (default parameters: 9-bit address,
// 8-bit data, setup 2, access 5). The ROM model returns addr[7:0]^0xA5 only
// while both chip-select and output-enable are low, 0xFF otherwise.
module tb_rom_read_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] start_address;
    logic [8:0] end_address;
    logic [7:0] rom_data;
    logic       data_ready;
    logic [8:0] rom_address;
    logic       rom_cs_n;
    logic       rom_oe_n;
    logic [7:0] data_out;
    logic [8:0] data_addr;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic       range_error;

    int checks   = 0;
    int failures = 0;

    rom_read_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_address (start_address),
        .end_address   (end_address),
        .rom_data      (rom_data),
        .data_ready    (data_ready),
        .rom_address   (rom_address),
        .rom_cs_n      (rom_cs_n),
        .rom_oe_n      (rom_oe_n),
        .data_out      (data_out),
        .data_addr     (data_addr),
        .data_valid    (data_valid),
        .busy          (busy),
        .done          (done),
        .range_error   (range_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = (!rom_cs_n && !rom_oe_n) ? (rom_address[7:0] ^ 8'hA5) : 8'hFF;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (rom_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b want=1", rom_cs_n); end
        checks++; if (rom_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b want=1", rom_oe_n); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", data_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (rom_address !== 9'h000) begin failures++; $display("FAIL reset_addr got=%h want=000", rom_address); end
        checks++; if (done !== 1'b0 || range_error !== 1'b0) begin failures++; $display("FAIL reset_pulses done=%b rerr=%b want=0,0", done, range_error); end
        $display("reset: idle outputs checked");
    endtask

    // Full sweep with data_ready high. Range inputs are scrambled after the
    // start is accepted, and optionally a start pulse is injected mid-sweep.
    task automatic test_sweep(input logic [8:0] sa, input logic [8:0] ea, input bit poke);
        int n;
        int got;
        int dones;
        logic [8:0] a;
        n = int'(ea) - int'(sa) + 1;
        got = 0;
        dones = 0;
        @(negedge clk);
        start = 1'b1; start_address = sa; end_address = ea;
        @(negedge clk);
        start = 1'b0; start_address = 9'h000; end_address = 9'h000;
        checks++; if (busy !== 1'b1 || rom_cs_n !== 1'b0 || rom_oe_n !== 1'b1) begin failures++; $display("FAIL sweep_accept busy=%b cs_n=%b oe_n=%b want=1,0,1", busy, rom_cs_n, rom_oe_n); end
        checks++; if (rom_address !== sa) begin failures++; $display("FAIL sweep_first_addr got=%h want=%h", rom_address, sa); end
        for (int k = 1; k <= 8 * n + 6; k++) begin
            @(negedge clk);
            start = (poke && k == 12);
            if (k == 1) begin
                checks++; if (rom_oe_n !== 1'b1) begin failures++; $display("FAIL sweep_oe_early got=%b want=1", rom_oe_n); end
            end
            if (k == 2) begin
                checks++; if (rom_oe_n !== 1'b0) begin failures++; $display("FAIL sweep_oe_fall got=%b want=0", rom_oe_n); end
            end
            if (range_error) begin
                checks++; failures++; $display("FAIL sweep_range_error got=1 want=0 at cycle %0d", k);
            end
            if (done) dones++;
            if (data_valid) begin
                a = sa + 9'(got);
                checks++; if (got >= n || k != 7 + 8 * got) begin failures++; $display("FAIL sweep_valid_timing cycle=%0d byte=%0d want_cycle=%0d", k, got, 7 + 8 * got); end
                checks++; if (data_addr !== a || data_out !== (a[7:0] ^ 8'hA5)) begin failures++; $display("FAIL sweep_byte addr=%h data=%h want addr=%h data=%h", data_addr, data_out, a, a[7:0] ^ 8'hA5); end
                $display("byte addr=%h data=%h cycle=%0d", data_addr, data_out, k);
                got++;
            end
        end
        start = 1'b0;
        checks++; if (got != n) begin failures++; $display("FAIL sweep_count got=%0d want=%0d", got, n); end
        checks++; if (dones != 1) begin failures++; $display("FAIL sweep_done_pulses got=%0d want=1", dones); end
        checks++; if (busy !== 1'b0 || rom_cs_n !== 1'b1) begin failures++; $display("FAIL sweep_end busy=%b cs_n=%b want=0,1", busy, rom_cs_n); end
        checks++; if (rom_address !== ea) begin failures++; $display("FAIL sweep_last_addr got=%h want=%h", rom_address, ea); end
        $display("sweep %h..%h: %0d bytes, %0d done pulses", sa, ea, got, dones);
    endtask

    task automatic test_basic_sweep();
        test_sweep(9'h010, 9'h013, 1'b0);
    endtask

    task automatic test_top_of_range();
        test_sweep(9'h1FE, 9'h1FF, 1'b0);
    endtask

    task automatic test_backpressure();
        bit found;
        int dones;
        found = 1'b0;
        dones = 0;
        data_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; start_address = 9'h005; end_address = 9'h005;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (data_valid) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL stall_valid_timeout got=0 want=1"); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (data_valid !== 1'b1 || data_out !== 8'hA0 || data_addr !== 9'h005 || rom_oe_n !== 1'b1) begin
                failures++; $display("FAIL stall_hold valid=%b data=%h addr=%h oe_n=%b want 1,a0,005,1", data_valid, data_out, data_addr, rom_oe_n);
            end
        end
        data_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == 0) begin
                checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL stall_accept valid=%b want=0", data_valid); end
            end
        end
        checks++; if (dones != 1 || busy !== 1'b0) begin failures++; $display("FAIL stall_done dones=%0d busy=%b want 1,0", dones, busy); end
        $display("stall: byte 005=a0 held 20 cycles then accepted");
    endtask

    task automatic test_range_error();
        @(negedge clk);
        start = 1'b1; start_address = 9'h009; end_address = 9'h003;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1 || range_error !== 1'b1) begin failures++; $display("FAIL rerr_pulse done=%b rerr=%b want 1,1", done, range_error); end
        checks++; if (busy !== 1'b0 || rom_cs_n !== 1'b1) begin failures++; $display("FAIL rerr_idle busy=%b cs_n=%b want 0,1", busy, rom_cs_n); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || range_error !== 1'b0 || busy !== 1'b0 || rom_cs_n !== 1'b1) begin
                failures++; $display("FAIL rerr_after done=%b rerr=%b busy=%b cs_n=%b want 0,0,0,1", done, range_error, busy, rom_cs_n);
            end
        end
        $display("range_error: start=009 end=003 rejected");
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        start = 1'b1; start_address = 9'h020; end_address = 9'h030;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rom_oe_n !== 1'b0) begin failures++; $display("FAIL midrst_in_access oe_n=%b want=0", rom_oe_n); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rom_address !== 9'h000 || rom_cs_n !== 1'b1 || rom_oe_n !== 1'b1) begin
            failures++; $display("FAIL midrst_rom addr=%h cs_n=%b oe_n=%b want 000,1,1", rom_address, rom_cs_n, rom_oe_n);
        end
        checks++; if (data_out !== 8'h00 || data_addr !== 9'h000 || data_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_data data=%h addr=%h valid=%b want 00,000,0", data_out, data_addr, data_valid);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || range_error !== 1'b0) begin
            failures++; $display("FAIL midrst_status busy=%b done=%b rerr=%b want 0,0,0", busy, done, range_error);
        end
        reset = 1'b0;
        $display("reset mid-access: outputs cleared");
        test_sweep(9'h020, 9'h023, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start_address = 9'h000;
        end_address = 9'h000;
        data_ready = 1'b1;
        test_reset();
        test_basic_sweep();
        test_top_of_range();
        test_backpressure();
        test_range_error();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
